// File: rtl/branch_predict_unit.sv
// Direct-mapped BTB with 2-bit direction counters: Fetch-stage lookup,
// Execute-stage branch resolution, misprediction redirect and perf counters.
module branch_predict_unit #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,

    input  logic [XLEN-1:0]  PCF,
    output logic             PredTakenF,
    output logic [XLEN-1:0]  PredTargetF,

    input  logic             BranchE,
    input  logic             JumpE,
    input  logic [2:0]       func3E,
    input  logic             EqE,
    input  logic             LtE,
    input  logic             LtuE,
    input  logic [XLEN-1:0]  PCE,
    input  logic [XLEN-1:0]  PCPlus4E,
    input  logic [XLEN-1:0]  PCTargetE,
    input  logic             PredTakenE,
    input  logic [XLEN-1:0]  PredTargetE,
    output logic             MispredictE,
    output logic [XLEN-1:0]  RedirectPCE,

    output logic [CNT_W-1:0] BranchCount,
    output logic [CNT_W-1:0] MispredictCount
);

    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX - 2;

    typedef struct packed {
        logic             valid;
        logic             jump;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  target;
        logic [1:0]       ctr;
    } btb_entry_t;

    localparam btb_entry_t RESET_ENTRY = '{
        valid:  1'b0,
        jump:   1'b0,
        tag:    '0,
        target: '0,
        ctr:    2'b01
    };

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [XLEN-1:0]  PC_STEP = XLEN'(4);

    btb_entry_t btb [ENTRIES];

    // ---------------- Fetch-stage lookup ----------------
    logic [IDX-1:0]   idx_f;
    logic [TAG_W-1:0] tag_f;
    btb_entry_t       ent_f;
    logic             hit_f;

    assign idx_f = PCF[IDX+1:2];
    assign tag_f = PCF[XLEN-1:IDX+2];
    assign ent_f = btb[idx_f];
    assign hit_f = ent_f.valid && (ent_f.tag == tag_f);

    // Gated by rst so the table contents before the first reset edge never leak out.
    assign PredTakenF  = !rst && hit_f && (ent_f.jump || ent_f.ctr[1]);
    assign PredTargetF = PredTakenF ? ent_f.target : PCF + PC_STEP;

    // ---------------- Execute-stage resolution ----------------
    logic cond_e;
    logic resolve_e;
    logic taken_e;

    always_comb begin
        // NOTE: default first so every path assigns cond_e and no latch is inferred.
        cond_e = 1'b0;
        unique case (func3E)
            3'b000:  cond_e = EqE;
            3'b001:  cond_e = !EqE;
            3'b100:  cond_e = LtE;
            3'b101:  cond_e = !LtE;
            3'b110:  cond_e = LtuE;
            3'b111:  cond_e = !LtuE;
            default: cond_e = 1'b0;
        endcase
    end

    assign resolve_e   = BranchE || JumpE;
    assign taken_e     = (BranchE && cond_e) || JumpE;
    assign RedirectPCE = taken_e ? PCTargetE : PCPlus4E;

    // A predicted-taken slot that turns out to be no branch at all is a stale alias.
    assign MispredictE = resolve_e
                       ? ((taken_e != PredTakenE) || (taken_e && (PredTargetE != PCTargetE)))
                       : PredTakenE;

    // ---------------- Table update ----------------
    logic [IDX-1:0]   idx_e;
    logic [TAG_W-1:0] tag_e;
    btb_entry_t       ent_e;
    btb_entry_t       ent_n;
    logic             hit_e;
    logic             write_e;

    assign idx_e = PCE[IDX+1:2];
    assign tag_e = PCE[XLEN-1:IDX+2];
    assign ent_e = btb[idx_e];
    assign hit_e = ent_e.valid && (ent_e.tag == tag_e);

    always_comb begin
        ent_n   = ent_e;
        write_e = 1'b0;
        if (resolve_e) begin
            if (hit_e) begin
                write_e   = 1'b1;
                ent_n.jump = JumpE;
                if (taken_e) begin
                    ent_n.target = PCTargetE;
                    if (ent_e.ctr != 2'b11) ent_n.ctr = ent_e.ctr + 2'b01;
                end else begin
                    if (ent_e.ctr != 2'b00) ent_n.ctr = ent_e.ctr - 2'b01;
                end
            end else if (taken_e) begin
                write_e      = 1'b1;
                ent_n.valid  = 1'b1;
                ent_n.jump   = JumpE;
                ent_n.tag    = tag_e;
                ent_n.target = PCTargetE;
                ent_n.ctr    = JumpE ? 2'b11 : 2'b10;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the table is reset entry by entry because valid bits must clear;
            // this forces flops rather than a RAM macro for the BTB.
            for (int i = 0; i < ENTRIES; i++) begin
                btb[i] <= RESET_ENTRY;
            end
            BranchCount     <= '0;
            MispredictCount <= '0;
        end else begin
            if (write_e) btb[idx_e] <= ent_n;
            if (resolve_e) BranchCount <= BranchCount + CNT_ONE;
            if (MispredictE) MispredictCount <= MispredictCount + CNT_ONE;
        end
    end

    logic unused_pc_bits;
    assign unused_pc_bits = ^{PCF[1:0], PCE[1:0]};

endmodule
